coef_stream_reader: RTL and testbench

COEF_STREAM_READER -- requirements
Module: coef_stream_reader

---
 rtl/coef_stream_pkg.sv | 14 +
 rtl/coef_stream_skid.sv | 53 +++++
 rtl/coef_stream_reader.sv | 168 ++++++++++++++++
 tb/tb_coef_stream_reader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coef_stream_pkg.sv
// coef_stream_pkg: shared parameter defaults and FSM state encoding for the
// coefficient stream reader and its skid buffer.
package coef_stream_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/coef_stream_skid.sv
// coef_stream_skid: two-entry FIFO between the RAM read port and the output
// stream. Entries are {last, data}. The occupancy is exported so the reader can
// throttle reads and never overflow the buffer.
module coef_stream_skid #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign out_valid = (cnt != 2'd0);
  // A full buffer can still take a word in the same cycle its head drains.
  assign in_ready  = (cnt != 2'd2) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = rd_ptr ? slot1 : slot0;
  assign count     = cnt;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) slot1 <= in_data;
        else        slot0 <= in_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/coef_stream_reader.sv
// coef_stream_reader: streams len words from a coefficient RAM (addresses
// 0..len-1) onto a valid/ready interface through a two-entry skid buffer.
// Optional macro COEF_STREAM_LOOP_EN adds a loop input that restarts the block
// at address 0 after each final beat instead of returning to IDLE.
//
// state | meaning
// IDLE  | waiting for start; address 0 is issued in the start cycle itself
// RUN   | issuing reads 1..len-1 whenever the buffer has room
// DRAIN | all reads issued, waiting for the final beat to handshake
module coef_stream_reader
  import coef_stream_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic [ADDR_W-1:0] ram_ad,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
`ifdef COEF_STREAM_LOOP_EN
  ,
  input  logic              loop
`endif
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rd_left;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_c;
  logic              in_flight;
  logic              in_last;
  logic [1:0]        occ;
  logic [1:0]        occ_after;
  logic              skid_in_ready;
  logic [DATA_W:0]   skid_out;
  logic              pop;
  logic              last_hs;
  logic              loop_restart;
  logic              credit_ok;
  logic              issue_raw;
  logic              issue_last;
  logic              issue;

  assign len_c   = (len > LEN_MAX) ? LEN_MAX : len;
  assign pop     = m_valid && m_ready;
  assign last_hs = pop && m_last;

  // The word leaving this cycle frees its slot, which keeps one beat per cycle.
  assign occ_after = occ - {1'b0, pop};
  assign credit_ok = skid_in_ready && ((occ_after + {1'b0, in_flight}) < 2'd2);

`ifdef COEF_STREAM_LOOP_EN
  assign loop_restart = (state == DRAIN) && last_hs && loop;
`else
  assign loop_restart = 1'b0;
`endif

  // Read-issue decision for the current cycle
  always_comb begin
    issue_raw  = 1'b0;
    issue_last = 1'b0;
    case (state)
      IDLE: begin
        issue_raw  = start && (len_c != '0);
        issue_last = (len_c == LEN_ONE);
      end
      RUN: begin
        issue_raw  = credit_ok;
        issue_last = (rd_left == LEN_ONE);
      end
      DRAIN: begin
        issue_raw  = loop_restart;
        issue_last = (len_q == LEN_ONE);
      end
      default: ;
    endcase
  end

  // Start is combinational into the RAM enable, so keep it quiet under reset.
  assign issue   = issue_raw && rst_n;
  assign ram_ce  = issue;
  assign ram_oce = 1'b1;
  assign ram_ad  = (state == RUN) ? rd_addr : '0;

  // Sequencer: state, address/remaining counters, in-flight tracking, busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      rd_left   <= '0;
      len_q     <= '0;
      in_flight <= 1'b0;
      in_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      in_flight <= issue;
      in_last   <= issue && issue_last;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len_c;
            if (len_c == '0) begin
              done <= 1'b1;
            end else begin
              busy    <= 1'b1;
              rd_addr <= ADDR_W'(1);
              rd_left <= len_c - LEN_ONE;
              state   <= (len_c == LEN_ONE) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            rd_left <= rd_left - LEN_ONE;
            if (rd_left == LEN_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_hs) begin
            done <= 1'b1;
            if (loop_restart) begin
              rd_addr <= ADDR_W'(1);
              rd_left <= len_q - LEN_ONE;
              state   <= (len_q == LEN_ONE) ? DRAIN : RUN;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  coef_stream_skid #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_flight),
    .in_data   ({in_last, ram_dout}),
    .in_ready  (skid_in_ready),
    .out_valid (m_valid),
    .out_data  (skid_out),
    .out_ready (m_ready),
    .count     (occ)
  );

  assign m_data = skid_out[DATA_W-1:0];
  assign m_last = m_valid && skid_out[DATA_W];

endmodule

// File: tb/tb_coef_stream_reader.sv
// tb_coef_stream_reader: directed stimulus with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_coef_stream_reader;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 16;
  localparam int LEN_MAX = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              busy, done, ram_ce, ram_oce;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_dout = '0;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready = 1'b1;
`ifdef COEF_STREAM_LOOP_EN
  logic              loop = 1'b0;
`endif

  coef_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .ram_ce   (ram_ce),
    .ram_oce  (ram_oce),
    .ram_ad   (ram_ad),
    .ram_dout (ram_dout),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready)
`ifdef COEF_STREAM_LOOP_EN
    ,
    .loop     (loop)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // RAM model: word k holds k (optionally xor-ed to exercise the sign bit)
  logic [DATA_W-1:0] ram_xor = '0;
  always @(posedge clk) if (ram_ce) ram_dout <= DATA_W'(ram_ad) ^ ram_xor;

  bit toggle_rdy = 1'b0;
  always @(posedge clk) if (toggle_rdy) begin #1; m_ready = ~m_ready; end

  // Reference model state
  logic [DATA_W:0]   exp_q[$];
  int                reads_left = 0, next_addr = 0, pending = 0, blk_len = 0;
  bit                done_exp = 0, busy_exp = 0, stall_prev = 0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;
  int                beats = 0, first_valid_cyc = -1, last_hs_cyc = -1, done_cyc = -1;
  int                done_count = 0, ce_count = 0;
  logic [DATA_W-1:0] last_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_pass(input int l);
    for (int k = 0; k < l; k++) exp_q.push_back({(k == l - 1), DATA_W'(k) ^ ram_xor});
  endtask

  always @(negedge clk) begin : monitor
    bit hs, nxt_done, nxt_busy;
    int l;
    logic [DATA_W:0] front;
    if (!rst_n) begin
      exp_q.delete();
      reads_left = 0; next_addr = 0; pending = 0;
      done_exp = 0; busy_exp = 0; stall_prev = 0;
    end else begin
      hs = m_valid && m_ready;
      nxt_done = 0;
      nxt_busy = busy_exp;
      chk("done", 32'(done), 32'(done_exp));
      chk("busy", 32'(busy), 32'(busy_exp));
      chk("ram_oce", 32'(ram_oce), 32'd1);
      if (done) begin done_count++; done_cyc = cyc; end
      if (start && !busy_exp) begin
        l = (int'(len) > LEN_MAX) ? LEN_MAX : int'(len);
        blk_len = l;
        if (l == 0) nxt_done = 1;
        else begin
          push_pass(l);
          reads_left = l; next_addr = 0; nxt_busy = 1;
        end
      end
      if (stall_prev) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
        chk("hold_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid) begin
        if (exp_q.size() == 0) chk("extra_beat", 32'(m_valid), 32'd0);
        else begin
          front = exp_q[0];
          chk("m_data", 32'(m_data), 32'(front[DATA_W-1:0]));
          chk("m_last", 32'(m_last), 32'(front[DATA_W]));
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (hs) begin
            void'(exp_q.pop_front());
            beats++;
            last_data = m_data;
            if (front[DATA_W]) begin
              last_hs_cyc = cyc;
              nxt_done = 1;
`ifdef COEF_STREAM_LOOP_EN
              if (loop) begin
                push_pass(blk_len);
                reads_left = blk_len; next_addr = 0;
              end else nxt_busy = 0;
`else
              nxt_busy = 0;
`endif
            end
          end
        end
      end else chk("m_last_idle", 32'(m_last), 32'd0);
      if (ram_ce) begin
        ce_count++;
        if (reads_left == 0) chk("extra_read", 32'(ram_ce), 32'd0);
        else begin
          chk("ram_ad", 32'(ram_ad), 32'(next_addr));
          chk("read_credit", 32'((pending - int'(hs)) < 2), 32'd1);
          next_addr++;
          reads_left--;
        end
      end
      pending = pending + int'(ram_ce) - int'(hs);
      done_exp = nxt_done;
      busy_exp = nxt_busy;
      stall_prev = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ram_ce"}, 32'(ram_ce), 32'd0);
    chk({tag, "_ram_oce"}, 32'(ram_oce), 32'd1);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_last"}, 32'(m_last), 32'd0);
    chk({tag, "_ram_ad"}, 32'(ram_ad), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
  endtask

  task automatic launch(input int l, output int s);
    beats = 0;
    first_valid_cyc = -1;
    start = 1'b1;
    len = (ADDR_W+1)'(l);
    s = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (done_count > d0) ok = 1;
      else step(1);
    end
    chk({nm, "_completes"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_beats(input int n, input int budget, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (beats >= n) ok = 1;
      else step(1);
    end
    chk({nm, "_beats_reached"}, 32'(ok), 32'd1);
  endtask

  task automatic run_block(input int l, input int budget, input string nm, output int s);
    int d0;
    d0 = done_count;
    launch(l, s);
    wait_done(d0, budget, nm);
    step(2);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s, d0, c0;
    // Reset with start held high: nothing may move
    rst_n = 1'b0; start = 1'b1; len = 10'd5; m_ready = 1'b1;
    #2;
    check_reset_vals("por");
    step(2);
    rst_n = 1'b1; start = 1'b0;
    step(2);

    // len=16, ready held: 16 back-to-back beats, first two cycles after start
    c0 = ce_count;
    run_block(16, 100, "a", s);
    chk("a_first_beat_cyc", 32'(first_valid_cyc), 32'(s + 2));
    chk("a_last_beat_cyc", 32'(last_hs_cyc), 32'(s + 17));
    chk("a_done_cyc", 32'(done_cyc), 32'(s + 18));
    chk("a_beats", 32'(beats), 32'd16);
    chk("a_last_data", 32'(last_data), 32'h000F);
    chk("a_reads", 32'(ce_count - c0), 32'd16);

    // len=8 with ready toggling every cycle
    c0 = ce_count;
    toggle_rdy = 1'b1;
    run_block(8, 100, "b", s);
    toggle_rdy = 1'b0;
    step(1);
    m_ready = 1'b1;
    step(1);
    chk("b_beats", 32'(beats), 32'd8);
    chk("b_last_data", 32'(last_data), 32'h0007);
    chk("b_reads", 32'(ce_count - c0), 32'd8);

    // len=0: done next cycle, no reads, no beats
    c0 = ce_count;
    run_block(0, 20, "c", s);
    chk("c_done_cyc", 32'(done_cyc), 32'(s + 1));
    chk("c_reads", 32'(ce_count - c0), 32'd0);
    chk("c_no_valid", 32'(first_valid_cyc), 32'(-1));

    // len=600 clamps to 512; top bit set in data must pass untouched
    ram_xor = 16'h8000;
    c0 = ce_count;
    run_block(600, 800, "d", s);
    chk("d_beats", 32'(beats), 32'd512);
    chk("d_last_data", 32'(last_data), 32'h81FF);
    chk("d_reads", 32'(ce_count - c0), 32'd512);
    chk("d_last_beat_cyc", 32'(last_hs_cyc), 32'(s + 513));
    ram_xor = '0;

    // Second start mid-block must be ignored
    d0 = done_count;
    c0 = ce_count;
    launch(4, s);
    start = 1'b1; len = 10'd7;
    step(1);
    start = 1'b0;
    wait_done(d0, 50, "e");
    step(10);
    chk("e_dones", 32'(done_count - d0), 32'd1);
    chk("e_beats", 32'(beats), 32'd4);
    chk("e_reads", 32'(ce_count - c0), 32'd4);
    chk("e_done_cyc", 32'(done_cyc), 32'(s + 6));

    // len=1 with the sink stalled: the single beat holds, carrying last
    d0 = done_count;
    m_ready = 1'b0;
    launch(1, s);
    step(4);
    chk("f_valid", 32'(m_valid), 32'd1);
    chk("f_data", 32'(m_data), 32'h0000);
    chk("f_last", 32'(m_last), 32'd1);
    m_ready = 1'b1;
    wait_done(d0, 20, "f");
    chk("f_beats", 32'(beats), 32'd1);
    chk("f_done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
    step(2);

    // Reset during beat 5 of a 32-word block, then a clean len=3 block
    launch(32, s);
    wait_beats(5, 100, "g");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid");
    d0 = done_count;
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("g_no_done", 32'(done_count - d0), 32'd0);
    c0 = ce_count;
    run_block(3, 30, "g2", s);
    chk("g2_beats", 32'(beats), 32'd3);
    chk("g2_last_data", 32'(last_data), 32'h0002);
    chk("g2_reads", 32'(ce_count - c0), 32'd3);
    chk("g2_first_beat_cyc", 32'(first_valid_cyc), 32'(s + 2));

`ifdef COEF_STREAM_LOOP_EN
    // Looping: passes repeat until loop drops, done on every pass
    d0 = done_count;
    loop = 1'b1;
    launch(4, s);
    wait_beats(6, 50, "h");
    loop = 1'b0;
    wait_beats(8, 50, "h2");
    step(6);
    chk("h_beats", 32'(beats), 32'd8);
    chk("h_dones", 32'(done_count - d0), 32'd2);
    chk("h_last_data", 32'(last_data), 32'h0003);
    chk("h_idle", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
